uart_rx: RTL and testbench

- UART receiver: the downstream stage that consumes the serial line driven by the UART transmitter.
- Samples `rx` on an oversampling enable tick, frames 1 start bit, NBITS data bits (LSB first) and 1 stop bit.
- Presents the received byte with a single-cycle `valid` strobe.
- Flags bad stop bits with `frame_err`; rejects glitches shorter than half a bit as false starts.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled start/data/stop
// framing (LSB first), single-cycle valid / frame_err strobes.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int NBITS      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             rx,
  output logic [NBITS-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    tick_cnt, tick_cnt_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [NBITS-1:0] shift, shift_d;
  logic [NBITS-1:0] data_d;
  logic             valid_d, frame_err_d;
  logic             rx_meta, rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shift     <= shift_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
    end
  end

  // Next-state logic; counters only move on tick, so a held-off tick freezes framing.
  always_comb begin
    state_d     = state;
    tick_cnt_d  = tick_cnt;
    bit_cnt_d   = bit_cnt;
    shift_d     = shift;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt + CW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            shift_d    = {rx_s, shift[NBITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = STOP;
            end else begin
              bit_cnt_d = bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt + CW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              data_d  = shift;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt + CW'(1);
          end
        end
      end

      // A held-low line (break) must return high before another start is accepted.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // Busy whenever a frame is in progress or the line is being waited on.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: randomized and directed frames, scoreboard checking.
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int NB   = 8;
  localparam int TDIV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          rx;
  logic [NB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;

  uart_rx #(.OVERSAMPLE(OS), .NBITS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          tick_en = 1'b1;
  int          lat_start = -1;
  logic [7:0]  last_good = 8'h00;
  logic [8:0]  exp_q[$];   // {is_frame_err, byte}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tick generator: one clk wide every TDIV clocks, gateable.
  initial begin
    int ph;
    ph = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = tick_en && (ph == 0);
      if (tick_en) ph = (ph + 1) % TDIV;
    end
  end

  // Wait for n ticks, then return at the following falling clock edge.
  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    @(negedge clk);
  endtask

  // Drive one frame; expected outcome follows directly from the stop bit value.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int gate_bit, input bit measure);
    rx = 1'b0;
    if (measure) lat_start = cyc;
    wait_ticks(OS);
    for (int i = 0; i < NB; i++) begin
      rx = b[i];
      if (i == gate_bit) begin
        wait_ticks(OS / 2);
        tick_en = 1'b0;
        repeat (50) @(negedge clk);
        tick_en = 1'b1;
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
    if (measure) check("busy_in_frame", busy, 1);
    exp_q.push_back({!stop, b});
    rx = stop;
    wait_ticks(OS);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an output.
  initial begin
    logic [8:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (valid || frame_err) begin
        check("pulse_excl", 32'(valid & frame_err), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out", {valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame_err_kind", frame_err, e[8]);
          check("valid_kind", valid, !e[8]);
          if (e[8]) begin
            check("data_hold", data, last_good);
          end else begin
            check("data", data, e[7:0]);
            last_good = e[7:0];
          end
        end
        if (valid && lat_start >= 0) begin
          d = cyc - lat_start;
          tests++;
          if (d < 607 || d > 610) begin
            fails++;
            $display("FAIL latency: got %0d clk expected 607..610 clk", d);
          end
          lat_start = -1;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bit st;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_ticks(20);

    // Good frame with latency and busy checks
    send_frame(8'hA5, 1'b1, -1, 1'b1);
    wait_ticks(4);
    check("busy_after_a5", busy, 0);
    check("data_a5", data, 8'hA5);

    // Short low glitch is a false start
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    check("busy_glitch", busy, 1);
    wait_ticks(8);
    check("busy_after_glitch", busy, 0);
    check("data_after_glitch", data, last_good);

    // Bad stop bit, line held low three bit times
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    wait_ticks(2 * OS);
    check("busy_break", busy, 1);
    check("data_after_ferr", data, 8'hA5);
    rx = 1'b1;
    wait_ticks(4);
    check("busy_break_end", busy, 0);
    send_frame(8'h81, 1'b1, -1, 1'b0);
    wait_ticks(4);
    check("data_81", data, 8'h81);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, -1, 1'b0);
    send_frame(8'hFF, 1'b1, -1, 1'b0);
    wait_ticks(4);
    check("data_ff", data, 8'hFF);

    // Reset in the middle of data bit 4 of 0x5A
    b = 8'h5A;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = b[4];
    wait_ticks(OS / 2);
    rst_n = 1'b0;
    last_good = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_outs", {data, valid, frame_err, busy}, 0);
    end
    rst_n = 1'b1;
    rx = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'hC3, 1'b1, -1, 1'b0);
    wait_ticks(4);
    check("data_c3", data, 8'hC3);

    // Tick gated off mid data bit 2
    send_frame(8'h96, 1'b1, 2, 1'b0);
    wait_ticks(4);
    check("data_96", data, 8'h96);

    // Randomized frames, some with bad stop bits
    for (int n = 0; n < 12; n++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      send_frame(b, st, -1, 1'b0);
      if (!st) begin
        wait_ticks(OS);
        rx = 1'b1;
        wait_ticks(OS);
      end else begin
        wait_ticks(int'($urandom_range(0, 20)));
      end
    end

    wait_ticks(2 * OS);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_data", data, last_good);
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
